lsnn_neuron_scheduler: RTL and testbench

Time-multiplexed controller that runs N virtual leaky-adaptive spiking neurons through one shared update datapath. Per timestep it accepts one input current per neuron over a valid/ready stream, updates each neuron's membrane state and adaptation in its register bank, and emits the spike vector with a valid/ready handshake. It sits between the input-current source and the spike consumer and replaces per-neuron datapath copies.

---
 rtl/lsnn_neuron_scheduler.sv | 140 ++++++++++++++
 tb/tb_lsnn_neuron_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsnn_neuron_scheduler.sv
// Time-multiplexed leaky-adaptive spiking neuron scheduler: one shared update
// datapath serves N virtual neurons per timestep, then hands off the spike vector.
module lsnn_neuron_scheduler #(
  parameter int         N_NEURONS = 4,
  parameter logic [7:0] ALPHA     = 8'd8,
  parameter logic [7:0] B0        = 8'd8,
  localparam int        IW        = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 step_start,
  input  logic                 cur_valid,
  output logic                 cur_ready,
  input  logic [7:0]           cur_data,
  output logic [IW-1:0]        cur_idx,
  output logic                 spk_valid,
  input  logic                 spk_ready,
  output logic [N_NEURONS-1:0] spk_vec,
  output logic                 busy,
  input  logic [IW-1:0]        thr_sel,
  output logic [7:0]           thr_out,
  output logic [15:0]          step_count
);

  typedef enum logic [1:0] {IDLE, ACCEPT, COMPUTE, EMIT} fsm_t;

  function automatic logic [7:0] sat8(input logic [8:0] v);
    return v[8] ? 8'hFF : v[7:0];
  endfunction

  function automatic logic [7:0] adapt_next(input logic [7:0] a, input logic spike);
    logic [7:0] decay;
    if (spike) return sat8({1'b0, a} + {3'b0, a[7:2]});
    decay = sat8({2'b0, a[7:1]} + {3'b0, a[7:2]});
    return (decay < ALPHA) ? ALPHA : decay;
  endfunction

  fsm_t                 fsm_q, fsm_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [7:0]           cur_q, cur_d;
  logic [7:0]           state_q [N_NEURONS];
  logic [7:0]           state_d [N_NEURONS];
  logic [7:0]           adapt_q [N_NEURONS];
  logic [7:0]           adapt_d [N_NEURONS];
  logic [N_NEURONS-1:0] spk_q, spk_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 cur_ready_q, cur_ready_d;
  logic                 spk_valid_q, spk_valid_d;
  logic                 busy_q, busy_d;

  logic [7:0] s_cur, a_cur, thr_cur;
  logic       spike;

  always_comb begin
    fsm_d   = fsm_q;
    idx_d   = idx_q;
    cur_d   = cur_q;
    state_d = state_q;
    adapt_d = adapt_q;
    spk_d   = spk_q;
    cnt_d   = cnt_q;
    // Pre-update values of the neuron being served
    s_cur   = state_q[idx_q];
    a_cur   = adapt_q[idx_q];
    thr_cur = sat8({1'b0, B0} + {1'b0, a_cur});
    spike   = (s_cur >= thr_cur);
    case (fsm_q)
      IDLE: begin
        if (step_start) begin
          idx_d = '0;
          fsm_d = ACCEPT;
        end
      end
      ACCEPT: begin
        if (cur_valid) begin
          cur_d = cur_data;
          fsm_d = COMPUTE;
        end
      end
      COMPUTE: begin
        state_d[idx_q] = sat8({1'b0, cur_q} + {2'b0, s_cur[7:1]});
        adapt_d[idx_q] = adapt_next(a_cur, spike);
        spk_d[idx_q]   = spike;
        if (idx_q == IW'(N_NEURONS - 1)) begin
          fsm_d = EMIT;
        end else begin
          idx_d = idx_q + IW'(1);
          fsm_d = ACCEPT;
        end
      end
      EMIT: begin
        if (spk_ready) begin
          cnt_d = cnt_q + 16'd1;
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
    cur_ready_d = (fsm_d == ACCEPT);
    spk_valid_d = (fsm_d == EMIT);
    busy_d      = (fsm_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      idx_q       <= '0;
      cur_q       <= '0;
      spk_q       <= '0;
      cnt_q       <= '0;
      cur_ready_q <= 1'b0;
      spk_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        state_q[i] <= '0;
        adapt_q[i] <= ALPHA;
      end
    end else begin
      fsm_q       <= fsm_d;
      idx_q       <= idx_d;
      cur_q       <= cur_d;
      spk_q       <= spk_d;
      cnt_q       <= cnt_d;
      cur_ready_q <= cur_ready_d;
      spk_valid_q <= spk_valid_d;
      busy_q      <= busy_d;
      state_q     <= state_d;
      adapt_q     <= adapt_d;
    end
  end

  assign cur_ready  = cur_ready_q;
  assign spk_valid  = spk_valid_q;
  assign busy       = busy_q;
  assign cur_idx    = idx_q;
  assign spk_vec    = spk_q;
  assign step_count = cnt_q;
  assign thr_out    = sat8({1'b0, B0} + {1'b0, adapt_q[thr_sel]});

endmodule

// File: tb/tb_lsnn_neuron_scheduler.sv
// Directed bench for lsnn_neuron_scheduler (N=4, ALPHA=8, B0=8) with
// hand-computed spike vectors and thresholds.
module tb_lsnn_neuron_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       step_start = 1'b0;
  logic       cur_valid = 1'b0;
  logic       cur_ready;
  logic [7:0] cur_data = 8'd0;
  logic [1:0] cur_idx;
  logic       spk_valid;
  logic       spk_ready = 1'b0;
  logic [3:0] spk_vec;
  logic       busy;
  logic [1:0] thr_sel = 2'd0;
  logic [7:0] thr_out;
  logic [15:0] step_count;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  lsnn_neuron_scheduler #(.N_NEURONS(4), .ALPHA(8'd8), .B0(8'd8)) dut (
    .clk(clk), .rst_n(rst_n), .step_start(step_start),
    .cur_valid(cur_valid), .cur_ready(cur_ready), .cur_data(cur_data),
    .cur_idx(cur_idx), .spk_valid(spk_valid), .spk_ready(spk_ready),
    .spk_vec(spk_vec), .busy(busy), .thr_sel(thr_sel), .thr_out(thr_out),
    .step_count(step_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic thr_of(input int n, output int t);
    thr_sel = 2'(n);
    #1;
    t = int'(thr_out);
  endtask

  // One timestep: feeds c0..c3, optionally with random cur_valid gaps, a
  // stalled spike consumer, and step_start pokes in ACCEPT/COMPUTE/EMIT.
  task automatic run_step(input logic [7:0] c0, input logic [7:0] c1,
                          input logic [7:0] c2, input logic [7:0] c3,
                          input bit rnd, input int stall, input bit poke,
                          output logic [3:0] vec);
    logic [7:0] c [4];
    logic [3:0] held;
    int  t0;
    bit  done;
    bit  v;
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    @(negedge clk);
    step_start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    step_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      done = 1'b0;
      for (int k = 0; k < 64 && !done; k++) begin
        if (cur_ready && cur_idx == 2'(i)) begin
          v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
          cur_valid = v;
          cur_data  = c[i];
          if (poke && i == 1) step_start = 1'b1;
        end
        @(negedge clk);
        if (rnd) check_eq("busy_in_step", int'(busy), 1);
        if (cur_valid) begin
          cur_valid = 1'b0;
          done = 1'b1;
        end
      end
      if (!done) check_eq("accept_timeout", 0, 1);
      if (poke && i == 1) begin
        @(negedge clk);
        step_start = 1'b0;
      end
    end
    done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      if (spk_valid) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) check_eq("emit_timeout", 0, 1);
    if (!rnd && !poke) check_eq("latency", cyc - t0, 9);
    vec  = spk_vec;
    held = spk_vec;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_eq("stall_valid", int'(spk_valid), 1);
      check_eq("stall_vec", int'(spk_vec), int'(held));
      check_eq("stall_busy", int'(busy), 1);
    end
    spk_ready  = 1'b1;
    step_start = poke;
    @(negedge clk);
    spk_ready  = 1'b0;
    step_start = 1'b0;
    check_eq("valid_drop", int'(spk_valid), 0);
    if (poke) begin
      repeat (3) @(negedge clk);
      check_eq("poke_ignored_busy", int'(busy), 0);
    end
  endtask

  initial begin
    int t;
    bit found;
    logic [3:0] v;
    int exp_v [3] = '{1, 1, 0};
    int exp_t [3] = '{18, 20, 17};
    logic [7:0] cur2 [3] = '{8'd20, 8'd0, 8'd0};

    repeat (2) @(negedge clk);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_cur_ready", int'(cur_ready), 0);
    check_eq("rst_spk_valid", int'(spk_valid), 0);
    check_eq("rst_spk_vec", int'(spk_vec), 0);
    check_eq("rst_step_count", int'(step_count), 0);
    check_eq("rst_cur_idx", int'(cur_idx), 0);
    thr_of(0, t);
    check_eq("rst_thr0", t, 16);
    rst_n = 1'b1;

    run_step(8'd20, 8'd0, 8'd0, 8'd0, 1'b0, 0, 1'b0, v);
    check_eq("s1_vec", int'(v), 0);
    thr_of(0, t);
    check_eq("s1_thr0", t, 16);
    check_eq("s1_count", int'(step_count), 1);
    check_eq("s1_idx_hold", int'(cur_idx), 3);
    check_eq("s1_idle", int'(busy), 0);

    for (int s = 0; s < 3; s++) begin
      run_step(cur2[s], 8'd0, 8'd0, 8'd0, 1'b0, 0, 1'b0, v);
      check_eq("s2_vec", int'(v), exp_v[s]);
      thr_of(0, t);
      check_eq("s2_thr0", t, exp_t[s]);
    end
    check_eq("s2_count", int'(step_count), 4);

    // Neuron 2 driven at full scale: state pins at 255 and adapt climbs to 255
    for (int r = 1; r <= 20; r++) begin
      run_step(8'd0, 8'd0, 8'd255, 8'd0, 1'b0, 0, 1'b0, v);
      check_eq("sat_vec", int'(v), (r == 1) ? 0 : 4);
      if (r == 17) begin
        thr_of(2, t);
        check_eq("sat_thr2_r17", t, 243);
      end
      if (r >= 18) begin
        thr_of(2, t);
        check_eq("sat_thr2", t, 255);
      end
    end
    check_eq("sat_count", int'(step_count), 24);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_step(8'd20, 8'd0, 8'd20, 8'd0, 1'b1, 10, 1'b0, v);
    check_eq("bp1_vec", int'(v), 0);
    run_step(8'd20, 8'd0, 8'd0, 8'd0, 1'b1, 10, 1'b0, v);
    check_eq("bp2_vec", int'(v), 5);
    thr_of(0, t);
    check_eq("bp_thr0", t, 18);
    thr_of(2, t);
    check_eq("bp_thr2", t, 18);
    check_eq("bp_count", int'(step_count), 2);

    run_step(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 0, 1'b1, v);
    check_eq("poke_vec", int'(v), 1);
    check_eq("poke_count", int'(step_count), 3);

    // Abort a timestep while neuron 2 is being offered its current
    @(negedge clk);
    step_start = 1'b1;
    @(negedge clk);
    step_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (cur_ready && cur_idx == 2'd2) begin
        found = 1'b1;
        break;
      end
      if (cur_ready) begin
        cur_valid = 1'b1;
        cur_data  = 8'd20;
      end
      @(negedge clk);
      cur_valid = 1'b0;
    end
    check_eq("mid_reached_n2", int'(found), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_busy", int'(busy), 0);
    check_eq("mid_cur_ready", int'(cur_ready), 0);
    check_eq("mid_spk_valid", int'(spk_valid), 0);
    check_eq("mid_spk_vec", int'(spk_vec), 0);
    check_eq("mid_count", int'(step_count), 0);
    check_eq("mid_idx", int'(cur_idx), 0);
    thr_of(0, t);
    check_eq("mid_thr0", t, 16);
    @(negedge clk);
    rst_n = 1'b1;
    run_step(8'd20, 8'd0, 8'd0, 8'd0, 1'b0, 0, 1'b0, v);
    check_eq("post_vec", int'(v), 0);
    thr_of(0, t);
    check_eq("post_thr0", t, 16);
    check_eq("post_count", int'(step_count), 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
